enemy_formation_ctl: RTL
========================

# enemy_formation_ctl

Controls the enemy formation for the enemy render chain. Once per frame, in vertical blanking, it computes the formation base position, tracks which enemies are alive, and sequences wave respawn. Its registered position and alive outputs drive the per-enemy draw stages, so enemies move and disappear without tearing. Hit events come from the bullet/collision logic.

## Interface
Parameters:
- N_EN, 3: number of enemies in the formation (1..8).
- X_MIN, 64: leftmost x_base.
- X_MAX, 704: rightmost x_base. This already accounts for sprite width and enemy spacing.
- Y_START, 64: y_base at spawn.
- Y_MAX, 480: y_base saturation limit.
- STEP_X, 8: horizontal pixels per move step.
- STEP_Y, 16: vertical pixels per descend step.
- FRAME_DIV, 2: frames per move step (≥1).
- CLEAR_FRAMES, 60: frames between the last kill and respawn.

Ports:
- pclk, in, 1: pixel clock. This is the only clock.
- rst, in, 1: synchronous, active-high reset.
- vblnk_in, in, 1: vertical blank from the timing chain. Its rising edge is the frame tick.
- hit_valid, in, 1: one-cycle hit strobe.
- hit_idx, in, 3: index (0..N_EN-1) of the enemy that was hit.
- x_base, out, 11: formation x position.
- y_base, out, 11: formation y position.
- alive, out, N_EN: per-enemy alive flags. Bit n corresponds to enemy n.
- wave, out, 4: wave number.
- wave_clear, out, 1: one-cycle pulse when the last alive enemy dies.
- reached_bottom, out, 1: level, high while y_base == Y_MAX.

## Operation
Frame tick:
- `tick = vblnk_in & ~vblnk_q`, where vblnk_q is vblnk_in registered.

Step divider:
- div_cnt counts ticks. On the tick where div_cnt == FRAME_DIV-1, a step fires and div_cnt returns to 0.
- The divider runs only in the move and descend states.

FSM states: MOVE_R, DESC_R, MOVE_L, DESC_L, CLEARED.
- MOVE_R, on step:
  - If x_base+STEP_X ≥ X_MAX: x_base ← X_MAX and go to DESC_R.
  - Otherwise: x_base += STEP_X.
- DESC_R, on step: y_base ← min(y_base+STEP_Y, Y_MAX), then go to MOVE_L.
- MOVE_L, on step:
  - If x_base ≤ X_MIN+STEP_X: x_base ← X_MIN and go to DESC_L.
  - Otherwise: x_base −= STEP_X.
- DESC_L, on step: y_base ← min(y_base+STEP_Y, Y_MAX), then go to MOVE_R.
- CLEARED:
  - Position is frozen and clr_cnt counts ticks.
  - On the tick where clr_cnt == CLEAR_FRAMES-1, respawn: alive ← all ones, x_base ← X_MIN, y_base ← Y_START, wave ← min(wave+1, 15), div_cnt ← 0. Then go to MOVE_R.

Arithmetic:
- All position sums are computed 12 bits wide before comparison, so they cannot wrap.
- Outputs never leave the ranges [X_MIN, X_MAX] and [Y_START, Y_MAX].

Hits:
- A hit with hit_valid=1 and hit_idx<N_EN clears alive[hit_idx].
- A hit with hit_idx ≥ N_EN is ignored.
- A hit on an enemy that is already dead is ignored.
- Hits are ignored in CLEARED.

Wave clear:
- When alive becomes all zeros from a nonzero value, wave_clear pulses for exactly 1 cycle and the FSM enters CLEARED with clr_cnt=0.

Simultaneous events:
- A hit and a step in the same cycle are both applied.
- If the last kill coincides with a step, the step's position update is applied, and the state becomes CLEARED instead of the step's next state.

Bottom:
- reached_bottom is asserted while y_base == Y_MAX.
- Horizontal movement continues while at the bottom.
- The block takes no game-over action; that is handled by the game FSM.

## Timing
Reset values (after a synchronous rst):
- x_base=X_MIN, y_base=Y_START, alive=all ones, wave=0.
- wave_clear=0, reached_bottom=0.
- FSM in MOVE_R; div_cnt=0, clr_cnt=0, vblnk_q=0.
- rst asserted mid-move or in CLEARED returns the block to these values on the next edge.

Latencies:
- Frame tick: asserted the cycle after vblnk_in is first sampled high.
- Position and FSM updates: visible 1 cycle after the tick, which is inside vertical blank.
- Hit: alive bit cleared 1 cycle after the hit_valid sample.
- wave_clear: asserted on the same edge that alive becomes zero.

All outputs are registered and there are no combinational input-to-output paths.

## Configuration
ENEMY_SPEEDUP_EN:
- Defined: the effective divider is max(1, FRAME_DIV − wave), so each wave moves faster.
- Undefined: the divider is always FRAME_DIV and movement speed is constant.

## Test plan
- Reset, then 2 vblnk rising edges → x_base=72, y_base=64, alive=3'b111, FSM in MOVE_R.
- Run 160 ticks (80 steps) → x_base=704. 2 more ticks → y_base=80, FSM in MOVE_L. 2 more ticks → x_base=696.
- Hit, hit_idx=1 → alive=3'b101 next cycle. Then hit_idx=1 again, and hit_idx=5 → alive stays 3'b101.
- Kill idx 0 and then idx 2 → wave_clear pulses 1 cycle and position freezes. After 60 ticks → alive=3'b111, wave=1, x_base=64, y_base=64.
- Force repeated descends until y_base=480 → reached_bottom=1. Further descends keep y_base at 480.
- Assert rst in CLEARED with wave=3 → next cycle all reset values, wave=0, no wave_clear pulse.
- With ENEMY_SPEEDUP_EN defined, FRAME_DIV=2, and wave=1 → a step fires on every tick.

Source files
------------

// File: rtl/enemy_formation_ctl_if.sv
// Bus between the enemy formation controller and its frame-timing, collision and render-chain peers.
interface enemy_formation_ctl_if #(
    parameter int N_EN = 3
);
    logic            vblnk_in;
    logic            hit_valid;
    logic [2:0]      hit_idx;
    logic [10:0]     x_base;
    logic [10:0]     y_base;
    logic [N_EN-1:0] alive;
    logic [3:0]      wave;
    logic            wave_clear;
    logic            reached_bottom;

    modport master (
        output vblnk_in, hit_valid, hit_idx,
        input  x_base, y_base, alive, wave, wave_clear, reached_bottom
    );

    modport slave (
        input  vblnk_in, hit_valid, hit_idx,
        output x_base, y_base, alive, wave, wave_clear, reached_bottom
    );
endinterface

// File: rtl/enemy_formation_ctl.sv
// Enemy formation controller: per-frame sweep/descend motion, alive tracking and wave respawn.
// Optional macro ENEMY_SPEEDUP_EN shortens the step divider as the wave number grows.
module enemy_formation_ctl #(
    parameter int N_EN         = 3,
    parameter int X_MIN        = 64,
    parameter int X_MAX        = 704,
    parameter int Y_START      = 64,
    parameter int Y_MAX        = 480,
    parameter int STEP_X       = 8,
    parameter int STEP_Y       = 16,
    parameter int FRAME_DIV    = 2,
    parameter int CLEAR_FRAMES = 60
) (
    input  logic                  pclk,
    input  logic                  rst,
    enemy_formation_ctl_if.slave  bus
);

    typedef enum logic [2:0] {
        MOVE_R  = 3'd0,
        DESC_R  = 3'd1,
        MOVE_L  = 3'd2,
        DESC_L  = 3'd3,
        CLEARED = 3'd4
    } state_e;

    localparam logic [11:0]     X_MIN_W   = 12'(X_MIN);
    localparam logic [11:0]     X_MAX_W   = 12'(X_MAX);
    localparam logic [11:0]     Y_MAX_W   = 12'(Y_MAX);
    localparam logic [11:0]     STEP_X_W  = 12'(STEP_X);
    localparam logic [11:0]     STEP_Y_W  = 12'(STEP_Y);
    localparam logic [10:0]     X_MIN_O   = 11'(X_MIN);
    localparam logic [10:0]     X_MAX_O   = 11'(X_MAX);
    localparam logic [10:0]     Y_START_O = 11'(Y_START);
    localparam logic [10:0]     Y_MAX_O   = 11'(Y_MAX);
    localparam logic [7:0]      FDIV_W    = 8'(FRAME_DIV);
    localparam logic [15:0]     CLR_LAST  = 16'(CLEAR_FRAMES - 1);
    localparam logic [3:0]      N_EN_W    = 4'(N_EN);
    localparam logic [N_EN-1:0] ALL_ONES  = {N_EN{1'b1}};
    localparam logic [N_EN-1:0] ALL_ZERO  = {N_EN{1'b0}};

    state_e          state_q, state_d;
    logic            vblnk_q;
    logic [7:0]      div_cnt_q, div_cnt_d;
    logic [15:0]     clr_cnt_q, clr_cnt_d;
    logic [10:0]     x_base_q, x_base_d;
    logic [10:0]     y_base_q, y_base_d;
    logic [N_EN-1:0] alive_q, alive_d;
    logic [3:0]      wave_q, wave_d;
    logic            wave_clear_q, wave_clear_d;
    logic            reached_bottom_q, reached_bottom_d;

    logic            tick_s, moving_s, step_s, respawn_s, hit_ok_s, last_kill_s;
    logic [7:0]      div_lim_s;
    logic [N_EN-1:0] hit_mask_s, alive_hit_s;
    logic [11:0]     x_ext_s, x_sum_s, x_dif_s, y_sum_s;

    assign tick_s    = bus.vblnk_in & ~vblnk_q;
    assign moving_s  = (state_q != CLEARED);
    assign step_s    = tick_s && moving_s && (div_cnt_q >= (div_lim_s - 8'd1));
    assign respawn_s = (state_q == CLEARED) && tick_s && (clr_cnt_q == CLR_LAST);
    assign x_ext_s   = {1'b0, x_base_q};
    assign x_sum_s   = x_ext_s + STEP_X_W;
    assign x_dif_s   = x_ext_s - STEP_X_W;
    assign y_sum_s   = {1'b0, y_base_q} + STEP_Y_W;

`ifdef ENEMY_SPEEDUP_EN
    // Divider shrinks with the wave number, never below one frame per step.
    always_comb begin
        if (FDIV_W > {4'd0, wave_q}) begin
            div_lim_s = FDIV_W - {4'd0, wave_q};
        end else begin
            div_lim_s = 8'd1;
        end
    end
`else
    assign div_lim_s = FDIV_W;
`endif

    // Decode the hit into a one-hot kill mask; out-of-range or dead targets change nothing.
    always_comb begin
        for (int i = 0; i < N_EN; i++) begin
            hit_mask_s[i] = (bus.hit_idx == 3'(i));
        end
        hit_ok_s    = bus.hit_valid && ({1'b0, bus.hit_idx} < N_EN_W) && moving_s;
        alive_hit_s = alive_q & ~hit_mask_s;
        last_kill_s = hit_ok_s && (alive_q != ALL_ZERO) && (alive_hit_s == ALL_ZERO);
    end

    // FSM state register.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q <= MOVE_R;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a final kill overrides whatever the step would have chosen.
    always_comb begin
        state_d = state_q;
        if (last_kill_s) begin
            state_d = CLEARED;
        end else begin
            case (state_q)
                MOVE_R:  state_d = (step_s && (x_sum_s >= X_MAX_W)) ? DESC_R : MOVE_R;
                DESC_R:  state_d = step_s ? MOVE_L : DESC_R;
                MOVE_L:  state_d = (step_s && (x_ext_s <= (X_MIN_W + STEP_X_W))) ? DESC_L : MOVE_L;
                DESC_L:  state_d = step_s ? MOVE_R : DESC_L;
                CLEARED: state_d = respawn_s ? MOVE_R : CLEARED;
                default: state_d = MOVE_R;
            endcase
        end
    end

    // FSM outputs: position, divider, clear counter, alive and wave next values.
    always_comb begin
        x_base_d  = x_base_q;
        y_base_d  = y_base_q;
        alive_d   = alive_q;
        wave_d    = wave_q;
        div_cnt_d = div_cnt_q;
        clr_cnt_d = clr_cnt_q;

        if (moving_s && tick_s) begin
            div_cnt_d = step_s ? 8'd0 : (div_cnt_q + 8'd1);
        end else begin
            div_cnt_d = div_cnt_q;
        end

        case (state_q)
            MOVE_R: begin
                if (step_s) begin
                    x_base_d = (x_sum_s >= X_MAX_W) ? X_MAX_O : x_sum_s[10:0];
                end else begin
                    x_base_d = x_base_q;
                end
            end
            MOVE_L: begin
                if (step_s) begin
                    x_base_d = (x_ext_s <= (X_MIN_W + STEP_X_W)) ? X_MIN_O : x_dif_s[10:0];
                end else begin
                    x_base_d = x_base_q;
                end
            end
            DESC_R, DESC_L: begin
                if (step_s) begin
                    y_base_d = (y_sum_s >= Y_MAX_W) ? Y_MAX_O : y_sum_s[10:0];
                end else begin
                    y_base_d = y_base_q;
                end
            end
            CLEARED: begin
                if (respawn_s) begin
                    alive_d   = ALL_ONES;
                    x_base_d  = X_MIN_O;
                    y_base_d  = Y_START_O;
                    wave_d    = (wave_q == 4'd15) ? 4'd15 : (wave_q + 4'd1);
                    div_cnt_d = 8'd0;
                    clr_cnt_d = 16'd0;
                end else if (tick_s) begin
                    clr_cnt_d = clr_cnt_q + 16'd1;
                end else begin
                    clr_cnt_d = clr_cnt_q;
                end
            end
            default: begin
                x_base_d = X_MIN_O;
                y_base_d = Y_START_O;
            end
        endcase

        if (hit_ok_s) begin
            alive_d = alive_hit_s;
        end else begin
            alive_d = alive_d;
        end

        if (last_kill_s) begin
            clr_cnt_d = 16'd0;
        end else begin
            clr_cnt_d = clr_cnt_d;
        end

        wave_clear_d     = last_kill_s;
        reached_bottom_d = (y_base_d == Y_MAX_O);
    end

    // Datapath and output registers.
    always_ff @(posedge pclk) begin
        if (rst) begin
            vblnk_q          <= 1'b0;
            div_cnt_q        <= 8'd0;
            clr_cnt_q        <= 16'd0;
            x_base_q         <= X_MIN_O;
            y_base_q         <= Y_START_O;
            alive_q          <= ALL_ONES;
            wave_q           <= 4'd0;
            wave_clear_q     <= 1'b0;
            reached_bottom_q <= 1'b0;
        end else begin
            vblnk_q          <= bus.vblnk_in;
            div_cnt_q        <= div_cnt_d;
            clr_cnt_q        <= clr_cnt_d;
            x_base_q         <= x_base_d;
            y_base_q         <= y_base_d;
            alive_q          <= alive_d;
            wave_q           <= wave_d;
            wave_clear_q     <= wave_clear_d;
            reached_bottom_q <= reached_bottom_d;
        end
    end

    assign bus.x_base         = x_base_q;
    assign bus.y_base         = y_base_q;
    assign bus.alive          = alive_q;
    assign bus.wave           = wave_q;
    assign bus.wave_clear     = wave_clear_q;
    assign bus.reached_bottom = reached_bottom_q;

endmodule
